// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU and its command sequencer.
//   W         datapath width
//   OP_*      3-bit opcodes; OP_AND..OP_SLT double as the ALU sel encoding
//   seq_state_e  state encoding of alu_cmd_sequencer
package alu_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SLT     = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_ABSDIFF = 3'b110;
  localparam logic [2:0] OP_ILL     = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MUL    = 3'd2,
    ST_ADIFF2 = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts ALU requests over valid/ready, drives an external
// combinational ALU, and returns results over a second valid/ready handshake.
// MUL (repeated ADD) and ABSDIFF (SLT then SUB) are built from several passes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       request handshake; cmd_op/cmd_a/cmd_b payload
//   alu_a/alu_b/alu_sel       drive to the ALU; alu_out is its same-cycle result
//   rsp_valid/rsp_ready       response handshake; rsp_data/rsp_err payload
//
// state  | meaning
// IDLE   | waiting for a request, cmd_ready=1
// EXEC   | single ALU pass (ops 000-100), illegal op, or SLT step of ABSDIFF
// MUL    | accumulate a into acc, b times
// ADIFF2 | SUB step of ABSDIFF with operands ordered by the SLT result
// RESP   | result held until rsp_ready
module alu_cmd_sequencer
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  seq_state_e   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         less_q, less_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    less_d     = less_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = OP_AND;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (cmd_op == OP_MUL) begin
            acc_d   = '0;
            cnt_d   = cmd_b;
            state_d = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_ABSDIFF: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_sel = OP_SLT;
            less_d  = alu_out[0];
            state_d = ST_ADIFF2;
          end
          OP_ILL: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
          default: begin
            alu_a      = a_q;
            alu_b      = b_q;
            alu_sel    = op_q;
            rsp_data_d = alu_out;
            rsp_err_d  = 1'b0;
            state_d    = ST_RESP;
          end
        endcase
      end

      ST_MUL: begin
        alu_a   = acc_q;
        alu_b   = a_q;
        alu_sel = OP_ADD;
        if (cnt_q != '0) begin
          acc_d = alu_out;
          cnt_d = cnt_q - W'(1);
        end else begin
          rsp_data_d = acc_q;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end

      ST_ADIFF2: begin
        // Subtract the smaller operand from the larger so the result is |a-b|.
        alu_a      = less_q ? b_q : a_q;
        alu_b      = less_q ? a_q : b_q;
        alu_sel    = OP_SUB;
        rsp_data_d = alu_out;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      less_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      less_q     <= less_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Handshake outputs are masked while rst is held so nothing is offered or
  // accepted during reset, even before the first reset edge.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP) && !rst;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  always #5 clk = ~clk;

  // Reference model of the external ALU (unsigned SLT).
  always_comb begin
    alu_out = 4'h0;
    case (alu_sel)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b011: alu_out = alu_a - alu_b;
      3'b100: alu_out = {3'b000, (alu_a < alu_b)};
      default: alu_out = 4'h0;
    endcase
  end

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_data"}, rsp_data, e.data);
      check({name, "_err"}, rsp_err, e.err);
    end
  endtask

  // Issue one command with rsp_ready high, measure edges from accept to
  // rsp_valid, and report alu_sel for the first two cycles after accept.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_data, input logic exp_err, input int exp_lat,
                         output logic [2:0] sel1, output logic [2:0] sel2);
    int   lat;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    e.data = exp_data; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    sel1 = alu_sel;
    sel2 = 3'b000;
    check("cmd_ready_busy", cmd_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) sel2 = alu_sel;
    end
    check("latency", lat, exp_lat);
    pop_check("rsp");
    check("resp_alu_sel_idle", alu_sel, 0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s1, s2;
    logic       seen;
    exp_t       e;

    vecs[0]  = '{OP_ADD,     4'h9, 4'h8, 4'h1, 1'b0, 1};
    vecs[1]  = '{OP_SUB,     4'h2, 4'h5, 4'hD, 1'b0, 1};
    vecs[2]  = '{OP_SLT,     4'h3, 4'h7, 4'h1, 1'b0, 1};
    vecs[3]  = '{OP_SLT,     4'h7, 4'h3, 4'h0, 1'b0, 1};
    vecs[4]  = '{OP_AND,     4'hC, 4'hA, 4'h8, 1'b0, 1};
    vecs[5]  = '{OP_OR,      4'h5, 4'hA, 4'hF, 1'b0, 1};
    vecs[6]  = '{OP_MUL,     4'h3, 4'h5, 4'hF, 1'b0, 6};
    vecs[7]  = '{OP_MUL,     4'h7, 4'h3, 4'h5, 1'b0, 4};
    vecs[8]  = '{OP_MUL,     4'h9, 4'h0, 4'h0, 1'b0, 1};
    vecs[9]  = '{OP_ABSDIFF, 4'h2, 4'h9, 4'h7, 1'b0, 2};
    vecs[10] = '{OP_ABSDIFF, 4'h9, 4'h2, 4'h7, 1'b0, 2};
    vecs[11] = '{OP_ABSDIFF, 4'h4, 4'h4, 4'h0, 1'b0, 2};
    vecs[12] = '{OP_ILL,     4'h5, 4'h6, 4'h0, 1'b1, 1};
    vecs[13] = '{OP_ADD,     4'h1, 4'h1, 4'h2, 1'b0, 1};
    vecs[14] = '{OP_MUL,     4'hF, 4'hF, 4'h1, 1'b0, 16};
    vecs[15] = '{OP_SUB,     4'h0, 4'h1, 4'hF, 1'b0, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 4'h0; cmd_b = 4'h0;
    rsp_ready = 1'b0;

    // Reset behaviour
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_alu_a", alu_a, 0);
    check("post_rst_alu_b", alu_b, 0);
    check("post_rst_alu_sel", alu_sel, 0);
    check("post_rst_rsp_data", rsp_data, 0);
    check("post_rst_rsp_err", rsp_err, 0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_err,
              vecs[i].exp_lat, s1, s2);
      if (vecs[i].op <= OP_SLT) check("exec_sel", s1, vecs[i].op);
      if (vecs[i].op == OP_MUL) check("mul_sel", s1, OP_ADD);
      if (vecs[i].op == OP_ABSDIFF) begin
        check("adiff_sel1", s1, OP_SLT);
        check("adiff_sel2", s2, OP_SUB);
      end
    end

    // Backpressure, with a second request held across RESP->IDLE
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 4'h3; cmd_b = 4'h4;
    @(posedge clk);
    e.data = 4'h7; e.err = 1'b0; sb_q.push_back(e);
    @(negedge clk);
    cmd_op = OP_OR; cmd_a = 4'h1; cmd_b = 4'h2;
    check("bp_exec_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 4'h7);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    pop_check("bp_rsp");
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    e.data = 4'h3; e.err = 1'b0; sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("held_rsp_valid", rsp_valid, 1);
    pop_check("held_rsp");
    @(posedge clk);

    // Reset during the 3rd MUL cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_a = 4'h5; cmd_b = 4'h9;
    @(posedge clk);
    e.data = 4'hD; e.err = 1'b0; sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mul_busy_cmd_ready", cmd_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_rst_cmd_ready", cmd_ready, 0);
    check("abort_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_alu_sel", alu_sel, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_rsp", seen, 0);
    run_cmd(OP_ADD, 4'h2, 4'h3, 4'h5, 1'b0, 1, s1, s2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side controller for the 4-bit combinational ALU (sel: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT). It accepts operation requests over a valid/ready handshake and drives the ALU's a/b/sel inputs. It captures the ALU output and returns results over a second valid/ready handshake. It also builds two multi-cycle compound operations, MUL and ABSDIFF, out of repeated ALU passes. It sits between any requester (test sequencer, future datapath control) and the ALU instance, which remains external and is wired by the parent.

## Interface
- No parameters; datapath width fixed at 4 bits, opcode width 3 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  controller can accept a request.
- cmd_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL, 110 ABSDIFF, 111 illegal.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- alu_a  output  4  to ALU a.
- alu_b  output  4  to ALU b.
- alu_sel  output  3  to ALU sel.
- alu_out  input  4  from ALU out (combinational, same cycle).
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  4  result.
- rsp_err  output  1  1 = illegal opcode; rsp_data is then 0.

## Operation
- States: IDLE, EXEC, MUL, ADIFF2, RESP.
- IDLE: cmd_ready=1. Accept on cmd_valid && cmd_ready. On accept, latch op/a/b. Go to MUL for op 101 (acc<=0, cnt<=b), otherwise to EXEC.
- EXEC, ops 000–100: drive alu_a=a, alu_b=b, alu_sel=op. At the edge, rsp_data<=alu_out, rsp_err<=0, go to RESP. SLT returns 4'b000x.
- EXEC, op 110: drive sel=100 with a, b. Latch less=alu_out[0], go to ADIFF2.
- ADIFF2: drive sel=011 with (less ? b,a : a,b). rsp_data<=alu_out, go to RESP. Result is |a−b|.
- EXEC, op 111: ALU ignored. rsp_data<=0, rsp_err<=1, go to RESP.
- MUL: drive alu_a=acc, alu_b=a, sel=010.
  - If cnt≠0: acc<=alu_out, cnt<=cnt−1.
  - If cnt=0: rsp_data<=acc, go to RESP.
  - Result is (a·b) mod 16; b=0 yields 0.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- cmd_ready=0 in every state except IDLE. Requests arriving then are not accepted and must be held by the requester.
- ALU outputs outside active states (IDLE, RESP): alu_a=0, alu_b=0, alu_sel=000.
- All arithmetic is 4-bit modulo 16. No carry or overflow is reported.

## Timing
- Reset (rst high at an edge) sets state=IDLE, acc=0, cnt=0, less=0, rsp_data=0, rsp_err=0.
- While rst is high, cmd_ready=0 and rsp_valid=0. After the first edge with rst low, cmd_ready=1 and all ALU drive outputs are 0.
- Reset mid-operation, in any state, aborts the operation and discards any pending response. No rsp_valid is raised for the aborted command.
- Accept at edge k. rsp_valid rises after:
  - edge k+1 for ops 000–100 and 111;
  - edge k+2 for ABSDIFF;
  - edge k+1+b for MUL.
- Earliest next accept is the edge after the response handshake. Peak throughput is one single-pass command per 3 cycles.
- rsp_ready may be high before rsp_valid; the handshake completes on the first cycle rsp_valid is high.
- cmd_valid held high across a RESP→IDLE transition is accepted in the IDLE cycle.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_AND…OP_ILL (3-bit), shared with the ALU's sel encoding;
  - the state enum for this block;
  - the width constant W=4.
- Single module, no sub-module. The MUL accumulator and counter stay inline. The ALU is instantiated by the parent, not inside this block.

## Test plan
- ADD a=9, b=8 -> rsp_data=4'h1, rsp_err=0, rsp_valid one cycle after accept. SUB a=2, b=5 -> 4'hD.
- SLT a=3, b=7 -> 4'h1; SLT a=7, b=3 -> 4'h0. ALU sel observed as 100 during EXEC.
- MUL a=3, b=5 -> 15 after 6 cycles; MUL a=7, b=3 -> 5 (21 mod 16); MUL a=9, b=0 -> 0 after 1 cycle.
- ABSDIFF a=2, b=9 -> 7; a=9, b=2 -> 7; a=4, b=4 -> 0. Response 2 cycles after accept; sel sequence 100 then 011.
- Illegal op 111 -> rsp_err=1, rsp_data=0. The next command behaves normally.
- Backpressure and reset cases:
  - Hold rsp_ready=0 for 4 cycles: rsp_data stays stable, cmd_ready=0 throughout.
  - Assert rst at the 3rd cycle of MUL a=5, b=9: no response, IDLE and cmd_ready=1 one cycle after rst drops.
